// File: rtl/fir_decimator.sv
// Keep-one-in-N sample selector feeding a small first-word-fall-through FIFO
// with a valid/ready output and a sticky overflow flag.
module fir_decimator #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned DECIM_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_WIDTH-1:0]         data_in,
  input  logic                          in_valid,
  input  logic [DECIM_WIDTH-1:0]        decim_factor,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  input  logic                          clear_overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [DECIM_WIDTH-1:0] r_phase;
  logic [DECIM_WIDTH-1:0] r_factor;
  logic                   r_first;
  logic [DECIM_WIDTH-1:0] w_req;
  logic [DECIM_WIDTH-1:0] w_n;
  logic                   w_wrap;
  logic                   w_keep;

  logic [DATA_WIDTH-1:0]  r_mem [FIFO_DEPTH];
  logic [LW-1:0]          r_wr_ptr;
  logic [LW-1:0]          r_rd_ptr;
  logic                   r_overflow;
  logic [LW-1:0]          w_level;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_pop;
  logic                   w_push;
  logic                   w_drop;

  // The factor in use is the latched one, except on the first valid sample after reset.
  assign w_req  = (decim_factor == '0) ? DECIM_WIDTH'(1) : decim_factor;
  assign w_n    = r_first ? w_req : r_factor;
  assign w_wrap = in_valid && (r_phase == (w_n - DECIM_WIDTH'(1)));
  assign w_keep = in_valid && (r_phase == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_phase  <= '0;
      r_factor <= DECIM_WIDTH'(1);
      r_first  <= 1'b1;
    end else if (in_valid) begin
      r_first <= 1'b0;
      r_phase <= w_wrap ? '0 : (r_phase + DECIM_WIDTH'(1));
      if (w_wrap || r_first) begin
        r_factor <= w_req;
      end
    end
  end

  assign w_level = r_wr_ptr - r_rd_ptr;
  assign w_full  = (w_level == LW'(FIFO_DEPTH));
  assign w_empty = (w_level == '0);
  assign w_pop   = !w_empty && out_ready;
  // A pop in the same cycle frees the slot a full FIFO needs for the push.
  assign w_push  = w_keep && (!w_full || w_pop);
  assign w_drop  = w_keep && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + LW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + LW'(1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (clear_overflow) begin
        r_overflow <= 1'b0;
      end
    end
  end

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= data_in;
    end
  end

  assign out_data   = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
  assign out_valid  = !w_empty;
  assign fifo_level = w_level;
  assign overflow   = r_overflow;

endmodule

// File: doc/fir_decimator.md
# fir_decimator

Downstream stage of the FIR filter. It takes the filtered sample stream, keeps one sample in every N, where N is programmable at run time, and buffers the kept samples in a small first-word-fall-through (FWFT) FIFO. The FIFO presents them on a valid/ready interface to the consumer (DSP back-end or host capture). Anti-alias filtering is done upstream; this block only selects, buffers and flags overflow.

## Interface
Parameters:
- DATA_WIDTH, 16, sample width. Same as the filter's output width.
- FIFO_DEPTH, 8, number of FIFO entries. Power of two, at least 2.
- DECIM_WIDTH, 8, width of the decimation-factor input.

Ports:
- clk  in  1  single clock for the whole block.
- reset  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
- data_in  in  DATA_WIDTH  filtered sample from the FIR filter. Treated as opaque bits; no arithmetic is applied.
- in_valid  in  1  data_in carries a new sample this cycle. The block never back-pressures the filter.
- decim_factor  in  DECIM_WIDTH  keep 1 of every decim_factor samples. 0 is treated as 1.
- out_data  out  DATA_WIDTH  FIFO head. Forced to 0 when the FIFO is empty.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts out_data this cycle.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  number of occupied entries.
- overflow  out  1  sticky flag: a kept sample was dropped because the FIFO was full.
- clear_overflow  in  1  synchronous clear for overflow.

## Operation
- Phase counter `phase`, 0 .. N-1, where N is the active factor.
  - Advances only on cycles with in_valid=1.
  - A sample is kept when in_valid=1 and phase==0.
- Factor latching:
  - decim_factor is latched into the active factor only when phase wraps to 0, and on the first valid sample after reset.
  - A mid-period change takes effect from the next kept sample. The current period is never truncated.
- Wrap rule: when in_valid=1 and phase==N-1 (with N=1 this is every valid cycle), phase goes to 0 on that edge.
- Push: a kept sample is written at wr_ptr, and wr_ptr increments modulo FIFO_DEPTH.
- Pop: when out_valid=1 and out_ready=1, rd_ptr increments. out_ready while the FIFO is empty is ignored.
- FIFO boundary behaviour:
  - Full and push with no pop: the sample is dropped, overflow is set, and level, pointers and contents are unchanged.
  - Full and push with pop in the same cycle: both happen, level stays at FIFO_DEPTH, and overflow is not set.
  - Empty and push: out_valid rises the next cycle; the pop is not combinationally bypassed.
  - Push and pop in the same cycle (not full): level is unchanged.
- Overflow flag:
  - clear_overflow=1 clears overflow.
  - If a drop occurs in the same cycle as clear_overflow, the set wins and overflow stays 1.
- Pointers carry an extra wrap bit; level is wr_ptr minus rd_ptr.
- Reset values:
  - phase=0, active factor=1.
  - Pointers 0, fifo_level=0, out_valid=0, out_data=0, overflow=0.
  - FIFO contents are not cleared; they are don't-care.
  - Reset asserted mid-stream discards all buffered samples. The first valid sample after release is kept.

## Timing
- Kept sample accepted at edge k is visible on out_data with out_valid=1 in cycle k+1, giving 1-cycle latency.
- Pop at edge k: the next head appears on out_data in cycle k+1. out_data is a combinational read of the registered memory.
- fifo_level and overflow are registered and update on the same edge as the push or pop that changes them.
- Sustained throughput: 1 output per N valid inputs. With out_ready held high the FIFO never exceeds 1 entry.
- No combinational path from out_ready to out_valid or to any input.

## Test plan
- Factor 4, in_valid=1 continuous, data_in = 0,1,2,…,15, out_ready=1:
  - Outputs are exactly 0,4,8,12.
  - fifo_level never exceeds 1.
  - overflow=0 throughout.
- Factor 0 with in_valid toggling 1,0,1,0 and data 10,x,11,x:
  - Outputs are 10 and 11; factor 0 behaves as 1.
  - The phase counter does not advance on invalid cycles.
- Factor 1, out_ready=0, 10 consecutive samples 0..9:
  - fifo_level=8 and overflow=1 after the 9th sample.
  - Raising out_ready then drains 0..7 in order.
  - clear_overflow then returns overflow to 0.
- FIFO full, push and pop in the same cycle:
  - Level stays 8, overflow stays 0.
  - The new sample lands at the tail and is drained last.
- Factor 2, then decim_factor changed to 3 while phase=1, data 0..9:
  - Outputs are 0,2,5,8; the new factor is applied only after the wrap.
- Reset pulsed while the FIFO holds 3 entries and phase=2:
  - The next cycle shows out_valid=0, fifo_level=0, out_data=0.
  - The next valid sample is kept immediately.
